// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants for the seven-segment display blocks.
//   HEX_PAT  : active-high segment patterns for hex digits 0..F
//              (bit6 = g ... bit0 = a).
//   SEG_OFF  : active-high pattern with every segment dark.
//   pol_mask : XOR mask that turns an active-high pattern into the pin
//              polarity of the board.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] HEX_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // An active-low board wants every bit flipped; an active-high board wants none.
  function automatic logic [6:0] pol_mask(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

endpackage

// File: rtl/seg7_hex_enc.sv
// seg7_hex_enc
//   Combinational nibble-to-segment encoder.
//   Ports:
//     nibble : hex digit to display
//     seg    : segment pattern in board polarity (bit6 = g ... bit0 = a)
module seg7_hex_enc
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_PAT[nibble] ^ pol_mask(SEG_ACTIVE_LOW);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for an N-digit seven-segment display. A frame
//   snapshot of value/dp_in is scanned one digit per DIV-cycle slot, with
//   anodes held off for the first GUARD cycles of each slot so the shared
//   segment lines can change without ghosting onto the neighbouring digit.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     value       : packed hex nibbles, nibble 0 is the rightmost digit
//     dp_in       : per-digit decimal point request (1 = lit)
//     blank_lz    : suppress leading zeros (sampled live)
//     enable      : 0 = display dark and scan frozen
//     seg, dp     : shared segment / decimal point lines (registered)
//     an          : per-digit anode enables (registered)
//     frame_tick  : one-cycle pulse when a new snapshot has been taken
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]     CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_DARK  = SEG_OFF ^ pol_mask(SEG_ACTIVE_LOW);
  localparam logic              DP_DARK   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_DARK   = {DIGITS{AN_ACTIVE_LOW}};

  // Scan state and frame snapshot
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] snap_val;
  logic [DIGITS-1:0]   snap_dp;

  logic                slot_end;
  logic                frame_end;

  assign slot_end  = enable && (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Current digit decode
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic [DIGITS-1:0] lz_mask;
  logic              zero_above;
  logic              blank_cur;
  logic [DIGITS-1:0] an_sel;
  logic [6:0]        enc_seg;
  logic [6:0]        seg_next;
  logic [DIGITS-1:0] an_next;

  always_comb begin
    cur_nib    = snap_val[idx*4 +: 4];
    cur_dp     = snap_dp[idx];

    // lz_mask[i] = 1 when snapshot nibbles DIGITS-1 down to i are all zero.
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (snap_val[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above;
    end

    // Digit 0 always shows, so an all-zero value still reads "0".
    blank_cur  = blank_lz && (idx != '0) && lz_mask[idx];

    an_sel      = '0;
    an_sel[idx] = 1'b1;

    seg_next = blank_cur ? SEG_DARK : enc_seg;
    // Anode stays off during the guard window while seg settles on the new digit.
    an_next  = (cnt >= CNT_GUARD) ? an_sel : '0;
  end

  seg7_hex_enc #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_enc (
    .nibble (cur_nib),
    .seg    (enc_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      snap_val   <= '0;
      snap_dp    <= '0;
      seg        <= SEG_DARK;
      dp         <= DP_DARK;
      an         <= AN_DARK;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (enable) begin
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // Snapshot only at frame end so a frame never mixes old and new digits.
        if (frame_end) begin
          snap_val <= value;
          snap_dp  <= dp_in;
        end
        seg <= seg_next;
        dp  <= cur_dp ^ SEG_ACTIVE_LOW;
        an  <= an_next ^ AN_DARK;
      end else begin
        seg <= SEG_DARK;
        dp  <= DP_DARK;
        an  <= AN_DARK;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GUARD  = 2;
  localparam int FRAME  = DIGITS * DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        enable;

  logic [6:0] seg_l, seg_h;
  logic       dp_l, dp_h;
  logic [3:0] an_l, an_h;
  logic       ft_l, ft_h;

  int checks   = 0;
  int failures = 0;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .enable(enable),
    .seg(seg_l), .dp(dp_l), .an(an_l), .frame_tick(ft_l)
  );

  seg7_scan_driver #(
    .DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .enable(enable),
    .seg(seg_h), .dp(dp_h), .an(an_h), .frame_tick(ft_h)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Active-high segment patterns for 0..F.
  logic [6:0] pat [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // m_pos = number of enabled cycles since reset; slot and phase follow by division.
  int          m_pos   = 0;
  logic [15:0] m_snap  = '0;
  logic [3:0]  m_sdp   = '0;
  bit          m_valid = 1'b0;
  logic [6:0]  e_seg;
  logic        e_dp, e_tick;
  logic [3:0]  e_an;
  int          m_slot, m_phase;
  logic [15:0] m_hi;

  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      m_pos = 0; m_snap = '0; m_sdp = '0;
      e_seg = '0; e_dp = 1'b0; e_an = '0; e_tick = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_slot  = (m_pos / DIV) % DIGITS;
      m_phase = m_pos % DIV;
      e_tick  = 1'b0;
      if (enable) begin
        m_hi  = m_snap >> (4 * m_slot);
        e_seg = (blank_lz && m_slot != 0 && m_hi == 16'h0) ? 7'h00 : pat[m_hi[3:0]];
        e_dp  = m_sdp[m_slot];
        e_an  = (m_phase >= GUARD) ? 4'(1 << m_slot) : 4'h0;
        if (m_pos % FRAME == FRAME - 1) begin
          m_snap = value;
          m_sdp  = dp_in;
          e_tick = 1'b1;
        end
        m_pos++;
      end else begin
        e_seg = '0; e_dp = 1'b0; e_an = '0;
      end
    end
    if (m_valid) begin
      check("cycle_lowpol",  {seg_l, dp_l, an_l, ft_l}, {~e_seg, ~e_dp, ~e_an, e_tick});
      check("cycle_highpol", {seg_h, dp_h, an_h, ft_h}, {e_seg, e_dp, e_an, e_tick});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (ft_l) ok = 1'b1;
    end
  endtask

  task automatic wait_an(input int d, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (an_l[d] == 1'b0) ok = 1'b1;
    end
  endtask

  task automatic wait_pos(input int p, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 80 && !ok; n++) begin
      @(negedge clk);
      if (m_pos % FRAME == p) ok = 1'b1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"},  an_l,  4'hF);
    check({tag, "_seg"}, seg_l, 7'h7F);
    check({tag, "_dp"},  dp_l,  1'b1);
    check({tag, "_ft"},  ft_l,  1'b0);
    check({tag, "_hi"},  {seg_h, dp_h, an_h, ft_h}, 13'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpi;
    logic        blz;
    int          digit;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit ok;
    int tick_at, bad, an1_cnt, overlap, nlow;
    int lows [4];

    tbl[0]  = '{16'h12AF, 4'h0, 1'b0, 0, 7'b0001110, 1'b1};
    tbl[1]  = '{16'h12AF, 4'h0, 1'b0, 1, 7'b0001000, 1'b1};
    tbl[2]  = '{16'h12AF, 4'h0, 1'b0, 2, 7'b0100100, 1'b1};
    tbl[3]  = '{16'h12AF, 4'h0, 1'b0, 3, 7'b1111001, 1'b1};
    tbl[4]  = '{16'h0050, 4'h0, 1'b1, 3, 7'h7F,      1'b1};
    tbl[5]  = '{16'h0050, 4'h0, 1'b1, 2, 7'h7F,      1'b1};
    tbl[6]  = '{16'h0050, 4'h0, 1'b1, 1, 7'b0010010, 1'b1};
    tbl[7]  = '{16'h0050, 4'h0, 1'b1, 0, 7'b1000000, 1'b1};
    tbl[8]  = '{16'h0000, 4'h8, 1'b1, 3, 7'h7F,      1'b0};
    tbl[9]  = '{16'h0000, 4'h8, 1'b1, 2, 7'h7F,      1'b1};
    tbl[10] = '{16'h0000, 4'h8, 1'b1, 1, 7'h7F,      1'b1};
    tbl[11] = '{16'h0000, 4'h8, 1'b1, 0, 7'b1000000, 1'b1};

    // Reset values
    reset = 1'b1; value = 16'h12AF; dp_in = 4'h0; blank_lz = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // First frame after release shows the zero snapshot; tick at cycle 32.
    reset = 1'b0;
    tick_at = 0; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ft_l && tick_at == 0) tick_at = k;
      if (k <= 32 && an_l != 4'hF && seg_l != 7'b1000000) bad++;
    end
    check("first_frame_zero", bad, 0);
    check("first_tick_cycle", tick_at, 32);

    // Table: scan order, leading-zero blanking, dp on blanked digit, both polarities
    for (int i = 0; i < 12; i++) begin
      value = tbl[i].val; dp_in = tbl[i].dpi; blank_lz = tbl[i].blz;
      wait_tick(ok);
      check("tbl_tick_wait", ok, 1);
      wait_an(tbl[i].digit, ok);
      check("tbl_an_wait", ok, 1);
      check($sformatf("tbl%0d_seg", i), seg_l, tbl[i].seg);
      check($sformatf("tbl%0d_dp", i), dp_l, tbl[i].dpo);
      check($sformatf("tbl%0d_an", i), an_l, 4'(~(4'b1 << tbl[i].digit)));
      check($sformatf("tbl%0d_seg_hi", i), seg_h, 7'(~tbl[i].seg));
      check($sformatf("tbl%0d_an_hi", i), an_h, 4'(4'b1 << tbl[i].digit));
    end

    // Ghosting guard: each anode low 6 of 8 cycles, never two at once
    value = 16'h12AF; dp_in = 4'h0; blank_lz = 1'b0;
    wait_tick(ok);
    check("ghost_tick_wait", ok, 1);
    for (int d = 0; d < 4; d++) lows[d] = 0;
    overlap = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      nlow = 0;
      for (int d = 0; d < 4; d++) if (!an_l[d]) begin lows[d]++; nlow++; end
      if (nlow > 1) overlap++;
    end
    for (int d = 0; d < 4; d++) check($sformatf("ghost_low_an%0d", d), lows[d], DIV - GUARD);
    check("ghost_overlap", overlap, 0);

    // Tear-free update
    value = 16'h1111;
    wait_tick(ok);
    check("tear_tick_wait", ok, 1);
    wait_pos(2 * DIV, ok);
    check("tear_pos_wait", ok, 1);
    value = 16'h2222;
    bad = 0; ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if ((!an_l[2] || !an_l[3]) && seg_l != 7'b1111001) bad++;
      if (ft_l) ok = 1'b1;
    end
    check("tear_tick2_wait", ok, 1);
    check("tear_old_digits", bad, 0);
    bad = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (an_l != 4'hF && seg_l != 7'b0100100) bad++;
    end
    check("tear_new_frame", bad, 0);

    // Enable freeze: digit1 slot, cnt 5 already shown
    wait_pos(DIV + 6, ok);
    check("en_pos_wait", ok, 1);
    enable = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (an_l != 4'hF || seg_l != 7'h7F || dp_l != 1'b1 || ft_l) bad++;
    end
    check("en_dark", bad, 0);
    enable = 1'b1;
    an1_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!an_l[1]) an1_cnt++;
    end
    check("en_resume_an1", an1_cnt, 2);

    // Reset mid-scan at idx 3
    wait_pos(3 * DIV + 3, ok);
    check("rst_pos_wait", ok, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b0;
    bad = 0; tick_at = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (ft_l && tick_at == 0) tick_at = k;
      if (k <= 32 && an_l != 4'hF && seg_l != 7'b1000000) bad++;
    end
    check("midreset_zero_frame", bad, 0);
    check("midreset_tick_cycle", tick_at, 32);

    // Randomized run against the reference model
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      value  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in  = 4'($urandom);
      if ($urandom_range(0, 49) == 0) blank_lz = 1'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset = 1'b0; enable = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
